// File: rtl/pong_match_ctrl.sv
// Pong match controller: START/SERVE/PLAY/PAUSE/DONE flow, target score with
// win-by margin, serve rotation, optional auto-serve timeout and mode select.
// All outputs come straight from registers.
module pong_match_ctrl #(
   parameter int SCORE_W       = 4,
   parameter int WIN_SCORE     = 5,
   parameter int WIN_BY        = 2,
   parameter int SERVE_ROTATE  = 0,
   parameter int SERVE_TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         ball_status_i,
   input  logic [3:0]         mode_sel_i,
   input  logic               enter_i,
   input  logic               pause_i,
   output logic [2:0]         state_o,
   output logic [SCORE_W-1:0] score1_o,
   output logic [SCORE_W-1:0] score2_o,
   output logic               serve_o,
   output logic [1:0]         mode_o,
   output logic [1:0]         winner_o,
   output logic               point_o
);

   typedef enum logic [2:0] {
      S_START = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int TMR_W = (SERVE_TIMEOUT > 1) ? $clog2(SERVE_TIMEOUT) : 1;
   localparam int ROT_W = (SERVE_ROTATE > 1) ? $clog2(SERVE_ROTATE) : 1;
   localparam logic [SCORE_W-1:0] MAX_SC   = '1;
   localparam logic [SCORE_W-1:0] WIN_SC   = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W:0]   WIN_LEAD = (SCORE_W+1)'(WIN_BY);
   localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(SERVE_TIMEOUT - 1);
   localparam logic [ROT_W-1:0]   ROT_LAST = ROT_W'(SERVE_ROTATE - 1);

   state_t             state_q;
   logic [SCORE_W-1:0] score1_q, score2_q;
   logic               serve_q, point_q;
   logic [1:0]         mode_q, winner_q;
   logic [TMR_W-1:0]   tmr_q;
   logic [ROT_W-1:0]   rot_q;

   logic               p1_scored, p2_scored, scored, win_d, serve_d, timeout;
   logic [SCORE_W-1:0] sc, op, sc_d, op_d, score1_d, score2_d;
   logic [SCORE_W:0]   lead;
   logic [ROT_W-1:0]   rot_d;
   logic [1:0]         mode_dec;
   logic               mode_ok;

   // Score update for a rally: scorer +1, or opponent -1 when the scorer is
   // saturated so the lead still grows without wrapping; then the win test.
   always_comb begin
      p1_scored = (ball_status_i == 2'b01);
      p2_scored = (ball_status_i == 2'b10);
      scored    = p1_scored | p2_scored;
      sc        = p1_scored ? score1_q : score2_q;
      op        = p1_scored ? score2_q : score1_q;
      sc_d      = sc;
      op_d      = op;
      if (sc != MAX_SC)  sc_d = sc + 1'b1;
      else if (op != '0) op_d = op - 1'b1;
      lead      = {1'b0, sc_d} - {1'b0, op_d};
      win_d     = (sc_d >= WIN_SC) && (lead >= WIN_LEAD);
      score1_d  = p1_scored ? sc_d : op_d;
      score2_d  = p1_scored ? op_d : sc_d;
   end

   // Next server: rally loser, or toggle each time the point counter wraps.
   always_comb begin
      rot_d   = rot_q;
      serve_d = serve_q;
      if (SERVE_ROTATE == 0) begin
         serve_d = p1_scored;
      end else if (rot_q == ROT_LAST) begin
         rot_d   = '0;
         serve_d = ~serve_q;
      end else begin
         rot_d   = rot_q + 1'b1;
      end
   end

   // Auto-serve fires on the last counted SERVE cycle; one-hot mode decode.
   always_comb begin
      timeout  = (SERVE_TIMEOUT != 0) && (tmr_q == TMR_LAST);
      mode_ok  = 1'b1;
      mode_dec = mode_q;
      case (mode_sel_i)
         4'b1000: mode_dec = 2'b00;
         4'b0100: mode_dec = 2'b01;
         4'b0010: mode_dec = 2'b10;
         4'b0001: mode_dec = 2'b11;
         default: mode_ok  = 1'b0;
      endcase
   end

   // Match FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_START;
         score1_q <= '0;
         score2_q <= '0;
         serve_q  <= 1'b0;
         mode_q   <= 2'b00;
         winner_q <= 2'b00;
         point_q  <= 1'b0;
         tmr_q    <= '0;
         rot_q    <= '0;
      end else begin
         point_q <= 1'b0;
         case (state_q)
            S_START: begin
               state_q  <= S_SERVE;
               score1_q <= '0;
               score2_q <= '0;
               serve_q  <= 1'b0;
               winner_q <= 2'b00;
               tmr_q    <= '0;
               rot_q    <= '0;
            end
            S_SERVE: begin
               if (mode_ok) mode_q <= mode_dec;
               if (enter_i || timeout) begin
                  state_q <= S_PLAY;
                  tmr_q   <= '0;
               end else if (SERVE_TIMEOUT != 0) begin
                  tmr_q   <= tmr_q + 1'b1;
               end
            end
            S_PLAY: begin
               if (scored) begin
                  score1_q <= score1_d;
                  score2_q <= score2_d;
                  point_q  <= 1'b1;
                  rot_q    <= rot_d;
                  if (win_d) begin
                     state_q  <= S_DONE;
                     winner_q <= ball_status_i;
                     serve_q  <= 1'b0;
                  end else begin
                     state_q  <= S_SERVE;
                     serve_q  <= serve_d;
                  end
               end else if (pause_i) begin
                  state_q <= S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (pause_i) state_q <= S_PLAY;
            end
            S_DONE: begin
               serve_q <= 1'b0;
               if (enter_i) state_q <= S_START;
            end
            default: state_q <= S_START;
         endcase
      end
   end

   assign state_o  = state_q;
   assign score1_o = score1_q;
   assign score2_o = score2_q;
   assign serve_o  = serve_q;
   assign mode_o   = mode_q;
   assign winner_o = winner_q;
   assign point_o  = point_q;

endmodule
